// File: rtl/instr_fetch_issue.sv
// Instruction fetch/issue sequencer: fetches words over REQ/ACK, holds them in IR
// and issues them over VALID/READY, with branch redirect, halt/resume and an issue counter.
module instr_fetch_issue #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            RST,
    output logic            MEM_REQ,
    output logic [PC_W-1:0] MEM_ADDR,
    input  logic            MEM_ACK,
    input  logic [15:0]     MEM_RDATA,
    output logic [15:0]     IR,
    output logic            IR_VALID,
    input  logic            IR_READY,
    output logic [PC_W-1:0] PC,
    input  logic            BR_TAKEN,
    input  logic [PC_W-1:0] BR_TARGET,
    input  logic            HALT,
    output logic            HALTED,
    output logic [15:0]     ISSUE_CNT
);

    typedef enum logic [1:0] {
        S_START,
        S_FETCH,
        S_ISSUE,
        S_HALT
    } stateT;

    stateT           state_q, state_d;
    logic [PC_W-1:0] npc_q, npc_d;
    logic [PC_W-1:0] reqAddr_q, reqAddr_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic [15:0]     issueCnt_q, issueCnt_d;
    logic            flush_q, flush_d;
    logic            handshake;
    logic            fetchAccept;

    assign handshake   = (state_q == S_ISSUE) && IR_READY;
    assign fetchAccept = (state_q == S_FETCH) && MEM_ACK && !flush_q && !BR_TAKEN;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_START;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; HALT is only honoured once no request is outstanding
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_START: state_d = HALT ? S_HALT : S_FETCH;
            S_FETCH: if (fetchAccept) state_d = S_ISSUE;
            S_ISSUE: if (handshake || BR_TAKEN) state_d = HALT ? S_HALT : S_FETCH;
            S_HALT:  if (!HALT) state_d = S_FETCH;
            default: state_d = S_START;
        endcase
    end

    // Output logic
    always_comb begin
        MEM_REQ   = (state_q == S_FETCH);
        IR_VALID  = (state_q == S_ISSUE);
        HALTED    = (state_q == S_HALT);
        MEM_ADDR  = reqAddr_q;
        IR        = ir_q;
        PC        = pc_q;
        ISSUE_CNT = issueCnt_q;
    end

    // Datapath next values; the request address is frozen while a fetch waits for ACK
    always_comb begin
        npc_d      = npc_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        flush_d    = flush_q;
        issueCnt_d = issueCnt_q;
        if (fetchAccept) begin
            ir_d  = MEM_RDATA;
            pc_d  = reqAddr_q;
            npc_d = reqAddr_q + PC_W'(1);
        end
        if (state_q == S_FETCH) begin
            if (MEM_ACK) begin
                flush_d = 1'b0;
            end else if (BR_TAKEN) begin
                flush_d = 1'b1;
            end
        end
        if (handshake) begin
            issueCnt_d = issueCnt_q + 16'd1;
        end
        if (BR_TAKEN) begin
            npc_d = BR_TARGET;
        end
        reqAddr_d = ((state_q == S_FETCH) && !MEM_ACK) ? reqAddr_q : npc_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            npc_q      <= RESET_PC;
            reqAddr_q  <= RESET_PC;
            pc_q       <= RESET_PC;
            ir_q       <= 16'h0000;
            flush_q    <= 1'b0;
            issueCnt_q <= 16'h0000;
        end else begin
            npc_q      <= npc_d;
            reqAddr_q  <= reqAddr_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            flush_q    <= flush_d;
            issueCnt_q <= issueCnt_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Directed bench for instr_fetch_issue: sequential fetch, wait states, branch flushes,
// halt/resume, async reset, plus a second instance checking PC wraparound.
module tb_instr_fetch_issue;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MEM_REQ;
    logic [15:0] MEM_ADDR;
    logic        MEM_ACK;
    logic [15:0] MEM_RDATA;
    logic [15:0] IR;
    logic        IR_VALID;
    logic        IR_READY;
    logic [15:0] PC;
    logic        BR_TAKEN;
    logic [15:0] BR_TARGET;
    logic        HALT;
    logic        HALTED;
    logic [15:0] ISSUE_CNT;

    logic        memReq2;
    logic [15:0] memAddr2;
    logic        memAck2;
    logic [15:0] memRdata2;
    logic [15:0] ir2;
    logic        irValid2;
    logic [15:0] pc2;
    logic        halted2;
    logic [15:0] issueCnt2;

    int          ackDelay = 0;
    int          waitCnt = 0;
    logic        useFixed = 1'b0;
    logic [15:0] fixedData = 16'h1234;
    logic [15:0] exp2 [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};

    int passCnt = 0;
    int checkCnt = 0;

    always #5 CLK = ~CLK;

    // Memory model: ACK after ackDelay cycles of continuous request, data = addr ^ 0A50
    assign MEM_ACK   = MEM_REQ && (waitCnt >= ackDelay);
    assign MEM_RDATA = useFixed ? fixedData : (MEM_ADDR ^ 16'h0A50);
    always @(posedge CLK) waitCnt <= (MEM_REQ && !MEM_ACK) ? waitCnt + 1 : 0;

    assign memAck2   = memReq2;
    assign memRdata2 = memAddr2 ^ 16'h0A50;

    instr_fetch_issue #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .CLK(CLK), .RST(RST),
        .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
        .IR(IR), .IR_VALID(IR_VALID), .IR_READY(IR_READY), .PC(PC),
        .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET),
        .HALT(HALT), .HALTED(HALTED), .ISSUE_CNT(ISSUE_CNT)
    );

    instr_fetch_issue #(.PC_W(16), .RESET_PC(16'hFFFE)) dutWrap (
        .CLK(CLK), .RST(RST),
        .MEM_REQ(memReq2), .MEM_ADDR(memAddr2), .MEM_ACK(memAck2), .MEM_RDATA(memRdata2),
        .IR(ir2), .IR_VALID(irValid2), .IR_READY(1'b1), .PC(pc2),
        .BR_TAKEN(1'b0), .BR_TARGET(16'h0000),
        .HALT(1'b0), .HALTED(halted2), .ISSUE_CNT(issueCnt2)
    );

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_req"}, 32'(MEM_REQ), 32'd0);
        checkOutput({tag, "_addr"}, 32'(MEM_ADDR), 32'h0000);
        checkOutput({tag, "_ir"}, 32'(IR), 32'h0000);
        checkOutput({tag, "_irvalid"}, 32'(IR_VALID), 32'd0);
        checkOutput({tag, "_pc"}, 32'(PC), 32'h0000);
        checkOutput({tag, "_halted"}, 32'(HALTED), 32'd0);
        checkOutput({tag, "_cnt"}, 32'(ISSUE_CNT), 32'd0);
    endtask

    initial begin
        RST       = 1'b1;
        IR_READY  = 1'b1;
        BR_TAKEN  = 1'b0;
        BR_TARGET = 16'h0000;
        HALT      = 1'b0;
        #2;
        checkResetState("reset");
        checkOutput("wrap_reset_addr", 32'(memAddr2), 32'hFFFE);
        @(negedge CLK);
        RST = 1'b0;

        // Zero-wait sequential run, both instances in lockstep
        for (int k = 0; k <= 8; k++) begin
            applyStimulus(1);
            if (k % 2 == 0) begin
                checkOutput("seq_req", 32'(MEM_REQ), 32'd1);
                checkOutput("seq_addr", 32'(MEM_ADDR), 32'(k / 2));
                checkOutput("seq_irvalid_lo", 32'(IR_VALID), 32'd0);
                checkOutput("seq_cnt", 32'(ISSUE_CNT), 32'(k / 2));
            end else begin
                checkOutput("seq_irvalid_hi", 32'(IR_VALID), 32'd1);
                checkOutput("seq_req_lo", 32'(MEM_REQ), 32'd0);
                checkOutput("seq_ir", 32'(IR), 32'((k / 2) ^ 16'h0A50));
                checkOutput("seq_pc", 32'(PC), 32'(k / 2));
            end
            if (k <= 5) begin
                if (k % 2 == 0) begin
                    checkOutput("wrap_req", 32'(memReq2), 32'd1);
                    checkOutput("wrap_addr", 32'(memAddr2), 32'(exp2[k / 2]));
                    checkOutput("wrap_halted", 32'(halted2), 32'd0);
                end else begin
                    checkOutput("wrap_irvalid", 32'(irValid2), 32'd1);
                    checkOutput("wrap_ir", 32'(ir2), 32'(exp2[k / 2] ^ 16'h0A50));
                    checkOutput("wrap_pc", 32'(pc2), 32'(exp2[k / 2]));
                    checkOutput("wrap_cnt", 32'(issueCnt2), 32'(k / 2));
                end
            end
        end

        // Wait states: ACK after 3 cycles, READY held low for 5 cycles
        ackDelay = 3;
        IR_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("wait_req", 32'(MEM_REQ), 32'd1);
            checkOutput("wait_addr", 32'(MEM_ADDR), 32'h0004);
            checkOutput("wait_irvalid", 32'(IR_VALID), 32'd0);
        end
        applyStimulus(1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_irvalid", 32'(IR_VALID), 32'd1);
            checkOutput("stall_ir", 32'(IR), 32'h0A54);
            checkOutput("stall_pc", 32'(PC), 32'h0004);
            checkOutput("stall_req", 32'(MEM_REQ), 32'd0);
            checkOutput("stall_cnt", 32'(ISSUE_CNT), 32'd4);
            applyStimulus(1);
        end
        IR_READY = 1'b1;
        checkOutput("stall_end_irvalid", 32'(IR_VALID), 32'd1);
        applyStimulus(1);
        checkOutput("stall_cnt_once", 32'(ISSUE_CNT), 32'd5);
        checkOutput("stall_next_addr", 32'(MEM_ADDR), 32'h0005);

        // Branch while a fetch is outstanding: late data must be dropped
        ackDelay  = 2;
        useFixed  = 1'b1;
        BR_TAKEN  = 1'b1;
        BR_TARGET = 16'h0040;
        checkOutput("brf_addr0", 32'(MEM_ADDR), 32'h0005);
        applyStimulus(1);
        BR_TAKEN = 1'b0;
        checkOutput("brf_addr_hold", 32'(MEM_ADDR), 32'h0005);
        checkOutput("brf_irvalid0", 32'(IR_VALID), 32'd0);
        applyStimulus(1);
        checkOutput("brf_ack_seen", 32'(MEM_ACK), 32'd1);
        checkOutput("brf_irvalid1", 32'(IR_VALID), 32'd0);
        applyStimulus(1);
        checkOutput("brf_irvalid2", 32'(IR_VALID), 32'd0);
        checkOutput("brf_ir_kept", 32'(IR), 32'h0A54);
        checkOutput("brf_req", 32'(MEM_REQ), 32'd1);
        checkOutput("brf_target", 32'(MEM_ADDR), 32'h0040);
        useFixed = 1'b0;
        ackDelay = 0;
        applyStimulus(1);
        checkOutput("brf_ir_new", 32'(IR), 32'h0A10);
        checkOutput("brf_pc_new", 32'(PC), 32'h0040);
        applyStimulus(1);
        checkOutput("brf_cnt", 32'(ISSUE_CNT), 32'd6);
        checkOutput("brf_seq_addr", 32'(MEM_ADDR), 32'h0041);

        // Branch in ISSUE without handshake, then with handshake
        IR_READY = 1'b0;
        applyStimulus(1);
        checkOutput("bri_ir", 32'(IR), 32'h0A11);
        checkOutput("bri_pc", 32'(PC), 32'h0041);
        BR_TAKEN  = 1'b1;
        BR_TARGET = 16'h0100;
        applyStimulus(1);
        BR_TAKEN = 1'b0;
        checkOutput("bri_irvalid_fall", 32'(IR_VALID), 32'd0);
        checkOutput("bri_cnt_same", 32'(ISSUE_CNT), 32'd6);
        checkOutput("bri_req", 32'(MEM_REQ), 32'd1);
        checkOutput("bri_target", 32'(MEM_ADDR), 32'h0100);
        applyStimulus(1);
        checkOutput("brh_ir", 32'(IR), 32'h0B50);
        BR_TAKEN = 1'b1;
        IR_READY = 1'b1;
        applyStimulus(1);
        BR_TAKEN = 1'b0;
        checkOutput("brh_cnt", 32'(ISSUE_CNT), 32'd7);
        checkOutput("brh_target", 32'(MEM_ADDR), 32'h0100);

        // HALT raised while a request is outstanding
        ackDelay = 1;
        HALT     = 1'b1;
        applyStimulus(1);
        checkOutput("halt_req_held", 32'(MEM_REQ), 32'd1);
        checkOutput("halt_addr_held", 32'(MEM_ADDR), 32'h0100);
        checkOutput("halt_not_yet", 32'(HALTED), 32'd0);
        applyStimulus(1);
        checkOutput("halt_issue", 32'(IR_VALID), 32'd1);
        checkOutput("halt_issue_pc", 32'(PC), 32'h0100);
        applyStimulus(1);
        checkOutput("halt_halted", 32'(HALTED), 32'd1);
        checkOutput("halt_no_req", 32'(MEM_REQ), 32'd0);
        checkOutput("halt_no_valid", 32'(IR_VALID), 32'd0);
        checkOutput("halt_cnt", 32'(ISSUE_CNT), 32'd8);
        applyStimulus(1);
        checkOutput("halt_stay", 32'(HALTED), 32'd1);
        checkOutput("halt_stay_req", 32'(MEM_REQ), 32'd0);
        HALT = 1'b0;
        applyStimulus(1);
        checkOutput("resume_halted", 32'(HALTED), 32'd0);
        checkOutput("resume_req", 32'(MEM_REQ), 32'd1);
        checkOutput("resume_addr", 32'(MEM_ADDR), 32'h0101);

        // Asynchronous reset in the middle of a fetch
        #2;
        RST = 1'b1;
        #1;
        checkResetState("async_rst");
        applyStimulus(1);
        checkResetState("rst_held");
        @(negedge CLK);
        RST = 1'b0;
        applyStimulus(1);
        checkOutput("post_rst_req", 32'(MEM_REQ), 32'd1);
        checkOutput("post_rst_addr", 32'(MEM_ADDR), 32'h0000);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/instr_fetch_issue.md
Name: instr_fetch_issue

Overview:
- Instruction fetch and issue sequencer for the 16-bit datapath.
- Fetches 16-bit instruction words from instruction memory over a REQ/ACK handshake, holds each word in the instruction register, and presents it to the decoder/ALU stage over a VALID/READY handshake.
- Handles branch redirects, halt/resume and an issued-instruction counter.

Parameters:
- PC_W, 16, width of program counter and memory address.
- RESET_PC, 16'h0000, fetch address after reset.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- MEM_REQ  output  1  read request to instruction memory.
- MEM_ADDR  output  PC_W  word address of the requested instruction.
- MEM_ACK  input  1  memory returns data this cycle; may be combinational with MEM_REQ.
- MEM_RDATA  input  16  instruction word, valid when MEM_ACK=1.
- IR  output  16  instruction register, drives the decoder.
- IR_VALID  output  1  IR holds an instruction awaiting issue.
- IR_READY  input  1  execute stage accepts IR this cycle.
- PC  output  PC_W  address of the instruction currently in IR.
- BR_TAKEN  input  1  single-cycle redirect strobe.
- BR_TARGET  input  PC_W  redirect address, sampled when BR_TAKEN=1.
- HALT  input  1  level; stop fetching after the current issue.
- HALTED  output  1  unit idle in the HALT state.
- ISSUE_CNT  output  16  count of completed issues.

Behaviour:
- Reset (asynchronous, immediate, also mid-transaction): MEM_REQ=0, MEM_ADDR=RESET_PC, IR=16'h0000, IR_VALID=0, PC=RESET_PC, HALTED=0, ISSUE_CNT=0, fetch pointer NPC=RESET_PC, flush flag=0, state=START. Any ACK in flight at reset is ignored.
- States:
  - START: one cycle, then FETCH (or HALT if HALT=1).
  - FETCH: MEM_REQ=1, MEM_ADDR=NPC, both held stable until MEM_ACK. On ACK with flush=0: IR<=MEM_RDATA, PC<=NPC, NPC<=NPC+1, go to ISSUE. On ACK with flush=1: data discarded, flush<=0, stay in FETCH; MEM_REQ is re-presented next cycle with the new NPC.
  - ISSUE: IR_VALID=1, MEM_REQ=0, IR/PC stable. Handshake occurs when IR_VALID&IR_READY: ISSUE_CNT<=ISSUE_CNT+1, then HALT if HALT=1, else FETCH.
  - HALT: HALTED=1, MEM_REQ=0, IR_VALID=0. Goes to FETCH the cycle after HALT=0.
- Latency: with a zero-wait memory (ACK in the REQ cycle), IR_VALID rises one cycle after ACK. Next MEM_REQ rises the cycle after the issue handshake. Peak throughput is one instruction per 2 cycles.
- Branch (BR_TAKEN=1), in all states, NPC<=BR_TARGET. Additionally:
  - FETCH, no ACK this cycle: flush<=1.
  - FETCH, ACK this cycle: returned data discarded, stay in FETCH.
  - ISSUE without handshake: IR_VALID drops next cycle, instruction is not counted, go to FETCH, or to HALT if HALT=1.
  - ISSUE with handshake in the same cycle: issue completes and is counted; next fetch is from BR_TARGET.
  - START/HALT: target retained; fetched on resume.
- BR_TAKEN while flush=1 overwrites NPC; flush stays 1.
- HALT asserted in FETCH: the outstanding request completes and the instruction issues, then the unit enters HALT. HALT is never entered with MEM_REQ=1 outstanding.
- Arithmetic: NPC+1 is modulo 2^PC_W (16'hFFFF -> 16'h0000). ISSUE_CNT wraps 16'hFFFF -> 16'h0000.
- MEM_REQ and IR_VALID are never 1 in the same cycle.

Test Plan:
- Zero-wait memory returning MEM_RDATA=addr^16'h0A50, IR_READY=1 constant, after reset:
  - MEM_ADDR follows 0,1,2,3.
  - IR=16'h0A50, 16'h0A51… with PC matching each word.
  - IR_VALID every 2nd cycle; ISSUE_CNT=4 after 8 cycles.
- Memory ACK delayed 3 cycles, IR_READY held 0 for 5 cycles:
  - MEM_ADDR/MEM_REQ stable while waiting for ACK.
  - IR/PC/IR_VALID stable while waiting for READY.
  - ISSUE_CNT increments exactly once per handshake.
- BR_TAKEN with BR_TARGET=16'h0040 in FETCH, ACK two cycles later (data 16'h1234): 16'h1234 never appears on IR with IR_VALID=1; next MEM_ADDR=16'h0040.
- BR_TAKEN with BR_TARGET=16'h0100 in ISSUE:
  - with IR_READY=0: IR_VALID falls, ISSUE_CNT unchanged, next MEM_ADDR=16'h0100.
  - repeated with IR_READY=1: ISSUE_CNT increments, next MEM_ADDR=16'h0100.
- RESET_PC=16'hFFFE, IR_READY=1: MEM_ADDR sequence FFFE, FFFF, 0000.
- Two further runs:
  - HALT=1 during FETCH: one more issue, then HALTED=1 with no MEM_REQ; HALT=0 resumes at the next sequential address.
  - RST pulsed mid-FETCH: all outputs return to reset values asynchronously.
